// File: rtl/sd_fifo_pkg.sv
// Shared definitions for the receive-FIFO drain path: defaults, FSM states and
// the fixed Wishbone classic-cycle encodings.
package sd_fifo_pkg;

    localparam int MEM_OFFSET_DEFAULT = 4;
    localparam int FIFO_AW_DEFAULT    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [3:0] WB_SEL_WORD    = 4'hF;

endpackage

// File: rtl/sd_fifo_rx_drain_if.sv
// Wishbone master bus bundle used by the receive drain engine.
interface sd_fifo_rx_drain_if;

    logic [31:0] m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;

    modport master (
        output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o,
        output m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        input  m_wb_ack_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o,
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        output m_wb_ack_i
    );

endinterface

// File: rtl/sd_rx_fifo_sync.sv
// Single-clock show-ahead FIFO with occupancy output and synchronous flush.
module sd_rx_fifo_sync #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int         DEPTH     = 2**AW;
    localparam logic [AW:0] DEPTH_LVL = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sd_fifo_rx_drain.sv
// Buffers received words and drains them to memory as single Wishbone classic
// writes at consecutive addresses starting from adr.
module sd_fifo_rx_drain
    import sd_fifo_pkg::*;
#(
    parameter int MEM_OFFSET = MEM_OFFSET_DEFAULT,
    parameter int FIFO_AW    = FIFO_AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    sd_fifo_rx_drain_if.master   wb,
    input  logic                 en,
    input  logic [31:0]          adr,
    input  logic [31:0]          dat_i,
    input  logic                 wr,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_AW:0]     level,
    output logic                 ovf
);

    drain_state_t state;
    logic [31:0]  offset;
    logic [31:0]  wr_dat;
    logic         bus_active;
    logic [31:0]  fifo_head;
    logic         fifo_pop;

    // Popping in IDLE is what launches a write, so the pop and the bus request share an edge.
    assign fifo_pop = en && (state == IDLE) && !empty;

    sd_rx_fifo_sync #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!en),
        .push  (wr && en),
        .pop   (fifo_pop),
        .din   (dat_i),
        .head  (fifo_head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign wb.m_wb_adr_o = adr + offset;
    assign wb.m_wb_dat_o = wr_dat;
    assign wb.m_wb_sel_o = WB_SEL_WORD;
    assign wb.m_wb_cti_o = WB_CTI_CLASSIC;
    assign wb.m_wb_bte_o = WB_BTE_LINEAR;
    assign wb.m_wb_cyc_o = bus_active;
    assign wb.m_wb_stb_o = bus_active;
    assign wb.m_wb_we_o  = bus_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= 1'b0;
        else if (!en)
            ovf <= 1'b0;
        else if (wr && full)
            ovf <= 1'b1;
    end

    // Dropping en aborts any write in flight and restarts addressing from adr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            offset     <= '0;
            wr_dat     <= '0;
            bus_active <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            offset     <= '0;
            bus_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        wr_dat     <= fifo_head;
                        bus_active <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (wb.m_wb_ack_i) begin
                        bus_active <= 1'b0;
                        offset     <= offset + 32'(MEM_OFFSET);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_fifo_rx_drain.sv
// Scoreboard bench for sd_fifo_rx_drain: words pushed are queued as expected
// bus writes and compared when the DUT raises its Wishbone cycle.
module tb_sd_fifo_rx_drain;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic        wr;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        ovf;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q [$];
    logic [31:0] exp_off;
    logic [31:0] exp_dat;
    logic [31:0] snap_adr;
    logic [31:0] snap_dat;

    sd_fifo_rx_drain_if wb_if ();

    sd_fifo_rx_drain #(
        .MEM_OFFSET (4),
        .FIFO_AW    (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb    (wb_if),
        .en    (en),
        .adr   (adr),
        .dat_i (dat_i),
        .wr    (wr),
        .full  (full),
        .empty (empty),
        .level (level),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_accept);
        dat_i = w;
        wr    = 1'b1;
        if (expect_accept)
            exp_q.push_back(w);
        tick();
        wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; wr = 1'b0; adr = 32'h0000_1000; dat_i = '0;
        wb_if.m_wb_ack_i = 1'b0;
        exp_off = '0;
        #12;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: cyc/stb/we=%b required 000",
                     {wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o});
        end
        n_checks++;
        if ({wb_if.m_wb_dat_o, wb_if.m_wb_sel_o, wb_if.m_wb_cti_o, wb_if.m_wb_bte_o} !==
            {32'h0, 4'hF, 3'b000, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: dat=%h sel=%h cti=%b bte=%b required 0/F/000/00",
                     wb_if.m_wb_dat_o, wb_if.m_wb_sel_o, wb_if.m_wb_cti_o, wb_if.m_wb_bte_o);
        end
        n_checks++;
        if ({level, empty, full, ovf} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_fifo: level=%0d empty=%b full=%b ovf=%b required 0/1/0/0",
                     level, empty, full, ovf);
        end
        n_checks++;
        if (wb_if.m_wb_adr_o !== 32'h0000_1000) begin
            n_fail++;
            $display("[TB] FAIL reset_adr: adr=%h required 00001000", wb_if.m_wb_adr_o);
        end
        tick();
        rst = 1'b1;
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic test_basic_writes();
        adr = 32'h0000_1000;
        exp_off = '0;
        push_word(32'hAAAA_0001, 1'b1);
        push_word(32'hBBBB_0002, 1'b1);
        push_word(32'hCCCC_0003, 1'b1);
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
            n_checks++;
            if (wb_if.m_wb_cyc_o !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL basic_cyc_timeout: cyc=%b required 1", wb_if.m_wb_cyc_o);
            end
            exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            n_checks++;
            if ({wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o} !==
                {adr + exp_off, exp_dat, 2'b11}) begin
                n_fail++;
                $display("[TB] FAIL basic_write%0d: adr=%h dat=%h stb=%b we=%b required %h/%h/1/1",
                         i, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o,
                         adr + exp_off, exp_dat);
            end
            wb_if.m_wb_ack_i = 1'b1;
            tick();
            wb_if.m_wb_ack_i = 1'b0;
            exp_off += 32'd4;
            n_checks++;
            if (wb_if.m_wb_cyc_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL basic_cyc_drop%0d: cyc=%b required 0", i, wb_if.m_wb_cyc_o);
            end
        end
        n_checks++;
        if ({level, empty} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL basic_drained: level=%0d empty=%b required 0/1", level, empty);
        end
    endtask

    task automatic test_ack_delay();
        push_word(32'hDDDD_0004, 1'b1);
        for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
        exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !== {1'b1, adr + exp_off, exp_dat}) begin
            n_fail++;
            $display("[TB] FAIL delay_start: cyc=%b adr=%h dat=%h required 1/%h/%h",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, adr + exp_off, exp_dat);
        end
        snap_adr = adr + exp_off;
        snap_dat = exp_dat;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !==
                {3'b111, snap_adr, snap_dat}) begin
                n_fail++;
                $display("[TB] FAIL delay_stable%0d: ctrl=%b adr=%h dat=%h required 111/%h/%h", k,
                         {wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o},
                         wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, snap_adr, snap_dat);
            end
        end
        wb_if.m_wb_ack_i = 1'b1;
        tick();
        wb_if.m_wb_ack_i = 1'b0;
        exp_off += 32'd4;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o} !== {1'b0, snap_adr + 32'd4}) begin
            n_fail++;
            $display("[TB] FAIL delay_single_inc: cyc=%b adr=%h required 0/%h",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, snap_adr + 32'd4);
        end
        // A stray ack with nothing in flight must not move the address.
        wb_if.m_wb_ack_i = 1'b1;
        tick();
        tick();
        wb_if.m_wb_ack_i = 1'b0;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o} !== {1'b0, adr + exp_off}) begin
            n_fail++;
            $display("[TB] FAIL idle_ack_ignored: cyc=%b adr=%h required 0/%h",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, adr + exp_off);
        end
    endtask

    task automatic test_overflow();
        en = 1'b0;
        tick();
        en = 1'b1;
        exp_off = '0;
        n_checks++;
        if (wb_if.m_wb_adr_o !== adr) begin
            n_fail++;
            $display("[TB] FAIL ovf_offset_clear: adr=%h required %h", wb_if.m_wb_adr_o, adr);
        end
        // The first word moves onto the bus, so 17 pushes are needed to fill 16 slots.
        for (int i = 0; i < 17; i++)
            push_word(32'hA500_0000 + 32'(i), 1'b1);
        n_checks++;
        if ({full, level, ovf} !== {1'b1, 5'd16, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL ovf_full: full=%b level=%0d ovf=%b required 1/16/0", full, level, ovf);
        end
        push_word(32'hA500_0011, 1'b0);
        n_checks++;
        if ({full, level, ovf} !== {1'b1, 5'd16, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL ovf_set: full=%b level=%0d ovf=%b required 1/16/1", full, level, ovf);
        end
        for (int i = 0; i < 17; i++) begin
            for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
            exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            n_checks++;
            if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !== {1'b1, adr + exp_off, exp_dat}) begin
                n_fail++;
                $display("[TB] FAIL ovf_write%0d: cyc=%b adr=%h dat=%h required 1/%h/%h", i,
                         wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, adr + exp_off, exp_dat);
            end
            wb_if.m_wb_ack_i = 1'b1;
            tick();
            wb_if.m_wb_ack_i = 1'b0;
            exp_off += 32'd4;
        end
        tick();
        tick();
        n_checks++;
        if ({wb_if.m_wb_cyc_o, empty, ovf} !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL ovf_after_drain: cyc=%b empty=%b ovf=%b required 0/1/1",
                     wb_if.m_wb_cyc_o, empty, ovf);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovf_clear: ovf=%b required 0", ovf);
        end
    endtask

    task automatic test_en_drop();
        adr = 32'h0000_2000;
        exp_off = '0;
        exp_q.delete();
        push_word(32'h1111_0001, 1'b1);
        for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
        exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !== {1'b1, 32'h0000_2000, exp_dat}) begin
            n_fail++;
            $display("[TB] FAIL drop_first: cyc=%b adr=%h dat=%h required 1/00002000/%h",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, exp_dat);
        end
        wb_if.m_wb_ack_i = 1'b1;
        tick();
        wb_if.m_wb_ack_i = 1'b0;
        for (int i = 0; i < 5; i++)
            push_word(32'h2222_0000 + 32'(i), 1'b0);
        n_checks++;
        if ({wb_if.m_wb_cyc_o, level, wb_if.m_wb_adr_o} !== {1'b1, 5'd4, 32'h0000_2004}) begin
            n_fail++;
            $display("[TB] FAIL drop_pre: cyc=%b level=%0d adr=%h required 1/4/00002004",
                     wb_if.m_wb_cyc_o, level, wb_if.m_wb_adr_o);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, level, wb_if.m_wb_adr_o} !== {2'b00, 5'd0, 32'h0000_2000}) begin
            n_fail++;
            $display("[TB] FAIL drop_abort: cyc=%b stb=%b level=%0d adr=%h required 0/0/0/00002000",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, level, wb_if.m_wb_adr_o);
        end
        en = 1'b1;
        push_word(32'h3333_0003, 1'b1);
        for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
        exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !== {1'b1, 32'h0000_2000, exp_dat}) begin
            n_fail++;
            $display("[TB] FAIL drop_reenable: cyc=%b adr=%h dat=%h required 1/00002000/%h",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, exp_dat);
        end
        wb_if.m_wb_ack_i = 1'b1;
        tick();
        wb_if.m_wb_ack_i = 1'b0;
    endtask

    task automatic test_adr_wrap();
        en = 1'b0;
        tick();
        en = 1'b1;
        adr = 32'hFFFF_FFFC;
        exp_off = '0;
        push_word(32'h4444_0001, 1'b1);
        push_word(32'h4444_0002, 1'b1);
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
            exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            n_checks++;
            if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !== {1'b1, adr + exp_off, exp_dat}) begin
                n_fail++;
                $display("[TB] FAIL wrap_write%0d: cyc=%b adr=%h dat=%h required 1/%h/%h", i,
                         wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, adr + exp_off, exp_dat);
            end
            wb_if.m_wb_ack_i = 1'b1;
            tick();
            wb_if.m_wb_ack_i = 1'b0;
            exp_off += 32'd4;
        end
        n_checks++;
        if (wb_if.m_wb_adr_o !== 32'h0000_0004) begin
            n_fail++;
            $display("[TB] FAIL wrap_final_adr: adr=%h required 00000004", wb_if.m_wb_adr_o);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0;
        tick();
        en = 1'b1;
        adr = 32'h0000_3000;
        exp_off = '0;
        exp_q.delete();
        push_word(32'h5555_0001, 1'b0);
        for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o, wb_if.m_wb_dat_o, level, empty} !==
            {3'b000, 32'h0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: ctrl=%b dat=%h level=%0d empty=%b required 000/0/0/1",
                     {wb_if.m_wb_cyc_o, wb_if.m_wb_stb_o, wb_if.m_wb_we_o}, wb_if.m_wb_dat_o, level, empty);
        end
        #2;
        rst = 1'b1;
        tick();
        n_checks++;
        if (wb_if.m_wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_idle: cyc=%b required 0", wb_if.m_wb_cyc_o);
        end
        push_word(32'h6666_0002, 1'b1);
        for (int t = 0; t < 20 && wb_if.m_wb_cyc_o !== 1'b1; t++) tick();
        exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        n_checks++;
        if ({wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o} !== {1'b1, 32'h0000_3000, exp_dat}) begin
            n_fail++;
            $display("[TB] FAIL async_resume: cyc=%b adr=%h dat=%h required 1/00003000/%h",
                     wb_if.m_wb_cyc_o, wb_if.m_wb_adr_o, wb_if.m_wb_dat_o, exp_dat);
        end
        wb_if.m_wb_ack_i = 1'b1;
        tick();
        wb_if.m_wb_ack_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_writes();
        test_ack_delay();
        test_overflow();
        test_en_drop();
        test_adr_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
